axi_burst_reader: RTL and testbench

- Parametrised AXI4 read master; successor to the single-beat DPI read path used by the fetch and LSU paths.
- Accepts one read request (address plus beat count) on a valid/ready port and issues one INCR burst on AR.
- Streams the returned R beats to the consumer through a 2-entry skid buffer with backpressure.
- Reports per-beat response errors; one burst outstanding at a time.

---
 rtl/axi_burst_reader.sv | 163 ++++++++++++++++
 tb/tb_axi_burst_reader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_reader.sv
// AXI4 read master: one request -> one INCR burst on AR, R beats streamed out through a 2-entry skid buffer.
// Optional AXI_BURST_READER_LEN_CHECK_EN: checks RLAST against the granted beat count.
module axi_burst_reader #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MAX_LEN = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST
);
  localparam int                SZ      = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN   = ~ADDR_W'((1 << SZ) - 1);
  localparam logic [7:0]        LEN_MAX = 8'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              r_state;
  logic                r_req_ready, r_arvalid, r_rready;
  logic [ADDR_W-1:0]   r_araddr;
  logic [7:0]          r_len;
  logic [DATA_W-1:0]   r_bdata [2];
  logic [1:0]          r_blast, r_berr;
  logic                r_wptr, r_rptr;
  logic [1:0]          r_cnt;

  logic w_rbeat, w_push, w_pop, w_plast, w_perr, w_done, w_drop_nxt;
  logic [1:0] w_cnt_nxt;
  logic w_unused;

  assign w_unused = RRESP[0];
  assign w_rbeat  = RVALID && r_rready;
  assign w_pop    = (r_cnt != 2'd0) && rsp_ready;
  assign w_done   = w_rbeat && RLAST;

`ifdef AXI_BURST_READER_LEN_CHECK_EN
  logic [7:0] r_beat;
  logic       r_drop;
  logic       w_lenend;
  assign w_lenend   = (r_beat == r_len);
  // After a missing RLAST the tail is swallowed until the slave finally signals it.
  assign w_push     = w_rbeat && !r_drop;
  assign w_plast    = RLAST | w_lenend;
  assign w_perr     = RRESP[1] | (RLAST ^ w_lenend);
  assign w_drop_nxt = r_drop | (w_rbeat && w_lenend && !RLAST);
`else
  assign w_push     = w_rbeat;
  assign w_plast    = RLAST;
  assign w_perr     = RRESP[1];
  assign w_drop_nxt = 1'b0;
`endif

  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_araddr    <= '0;
      r_len       <= '0;
`ifdef AXI_BURST_READER_LEN_CHECK_EN
      r_beat      <= '0;
      r_drop      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_araddr    <= req_addr & ALIGN;
            r_len       <= (req_len > LEN_MAX) ? LEN_MAX : req_len;
            r_req_ready <= 1'b0;
            r_arvalid   <= 1'b1;
            r_state     <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            // The buffer may still hold beats from the previous burst.
            r_rready  <= (w_cnt_nxt != 2'd2);
            r_state   <= DATA;
`ifdef AXI_BURST_READER_LEN_CHECK_EN
            r_beat    <= '0;
            r_drop    <= 1'b0;
`endif
          end
        end
        DATA: begin
`ifdef AXI_BURST_READER_LEN_CHECK_EN
          if (w_rbeat) r_beat <= r_beat + 8'd1;
          r_drop <= w_drop_nxt;
`endif
          if (w_done) begin
            r_rready    <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
`ifdef AXI_BURST_READER_LEN_CHECK_EN
            r_drop      <= 1'b0;
`endif
          end else begin
            r_rready <= w_drop_nxt || (w_cnt_nxt != 2'd2);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_bdata[0] <= '0;
      r_bdata[1] <= '0;
      r_blast    <= '0;
      r_berr     <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_push) begin
        r_bdata[r_wptr] <= RDATA;
        r_blast[r_wptr] <= w_plast;
        r_berr[r_wptr]  <= w_perr;
        r_wptr          <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign ARVALID   = r_arvalid;
  assign ARADDR    = r_araddr;
  assign ARLEN     = r_len;
  assign ARSIZE    = 3'(SZ);
  assign ARBURST   = 2'b01;
  assign RREADY    = r_rready;
  assign rsp_valid = (r_cnt != 2'd0);
  assign rsp_data  = r_bdata[r_rptr];
  assign rsp_last  = r_blast[r_rptr];
  assign rsp_err   = r_berr[r_rptr];
endmodule

// File: tb/tb_axi_burst_reader.sv
// Directed bench for axi_burst_reader: slave-beat queue drives R, expected rsp beats are scoreboarded.
module tb_axi_burst_reader;
  logic        ACLK, ARESETn;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [63:0] rsp_data;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        RVALID, RREADY, RLAST;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;

  axi_burst_reader #(.ADDR_W(32), .DATA_W(64), .MAX_LEN(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct { logic [63:0] d; logic [1:0] resp; logic last; } sbeat_t;
  typedef struct { logic [63:0] d; logic last; logic err; } ebeat_t;
  sbeat_t s_q[$];
  ebeat_t exp_q[$];
  int n_vec = 0, n_err = 0, n_pop = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_beat(input logic [63:0] d, input logic [1:0] resp, input logic last,
                          input logic elast, input logic eerr);
    sbeat_t s;
    ebeat_t e;
    s.d = d; s.resp = resp; s.last = last;
    e.d = d; e.last = elast; e.err = eerr;
    s_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // One clock: drive slave R, score any rsp handshake due at the coming edge, advance.
  task automatic cyc();
    logic w_r, w_rsp;
    ebeat_t e;
    if (s_q.size() > 0) begin
      RVALID = 1'b1; RDATA = s_q[0].d; RRESP = s_q[0].resp; RLAST = s_q[0].last;
    end else begin
      RVALID = 1'b0; RRESP = 2'b00; RLAST = 1'b0;
    end
    w_r   = RVALID && RREADY;
    w_rsp = rsp_valid && rsp_ready;
    if (w_rsp) begin
      chk("rsp_expected", 128'(exp_q.size() > 0), 128'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", 128'(rsp_data), 128'(e.d));
        chk("rsp_last", 128'(rsp_last), 128'(e.last));
        chk("rsp_err",  128'(rsp_err),  128'(e.err));
        n_pop++;
      end
    end
    @(posedge ACLK); #1;
    if (w_r && s_q.size() > 0) void'(s_q.pop_front());
  endtask

  task automatic do_req(input logic [31:0] a, input logic [7:0] l);
    int i;
    for (i = 0; i < 50 && !req_ready; i++) cyc();
    chk("req_ready_wait", 128'(req_ready), 128'(1));
    req_valid = 1'b1; req_addr = a; req_len = l;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_q.size() > 0 || s_q.size() > 0); i++) cyc();
    chk("drain_empty", 128'(exp_q.size() + s_q.size()), 128'(0));
  endtask

  logic [63:0] hold;
  int base;

  initial begin
    ARESETn = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b1;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0; RLAST = 1'b0;
    #3 ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_outs", {req_ready, ARVALID, RREADY, rsp_valid, rsp_last, rsp_err, ARADDR, ARLEN, rsp_data}, '0);
    ARESETn = 1'b1;
    cyc();
    chk("req_ready_after_rst", 128'(req_ready), 128'(1));

    // Back-to-back burst, unaligned address
    ARREADY = 1'b1;
    do_req(32'h8000_0013, 8'd3);
    chk("arvalid", 128'(ARVALID), 128'(1));
    chk("araddr", 128'(ARADDR), 128'(32'h8000_0010));
    chk("arlen", 128'(ARLEN), 128'(3));
    chk("arsize", 128'(ARSIZE), 128'(3));
    chk("arburst", 128'(ARBURST), 128'(1));
    chk("req_ready_busy", 128'(req_ready), 128'(0));
    for (int i = 0; i < 4; i++) add_beat(64'hD000_0000_0000_0000 + 64'(i), 2'b00, i == 3, i == 3, 1'b0);
    cyc();
    repeat (4) cyc();
    chk("tput_4cyc", 128'(exp_q.size()), 128'(1));
    cyc();
    chk("tput_5cyc", 128'(exp_q.size()), 128'(0));

    // Backpressure: stall consumer after first beat
    do_req(32'h0000_1000, 8'd3);
    for (int i = 0; i < 4; i++) add_beat(64'hB000_0000_0000_0010 + 64'(i), 2'b00, i == 3, i == 3, 1'b0);
    base = n_pop;
    for (int i = 0; i < 20 && n_pop - base < 1; i++) cyc();
    chk("bp_first_pop", 128'(n_pop - base), 128'(1));
    rsp_ready = 1'b0;
    hold = rsp_data;
    repeat (5) cyc();
    chk("bp_rready_low", 128'(RREADY), 128'(0));
    chk("bp_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("bp_rsp_hold", 128'(rsp_data), 128'(hold));
    chk("bp_slave_left", 128'(s_q.size()), 128'(1));
    rsp_ready = 1'b1;
    drain();

    // Delayed ARREADY, error on beat 2
    ARREADY = 1'b0;
    do_req(32'h2000_0008, 8'd3);
    for (int i = 0; i < 4; i++) begin
      chk("ar_hold_valid", 128'(ARVALID), 128'(1));
      chk("ar_hold_addr", 128'(ARADDR), 128'(32'h2000_0008));
      chk("ar_hold_len", 128'(ARLEN), 128'(3));
      chk("ar_hold_reqrdy", 128'(req_ready), 128'(0));
      cyc();
    end
    ARREADY = 1'b1;
    for (int i = 0; i < 4; i++)
      add_beat(64'hE000_0000_0000_0020 + 64'(i), (i == 2) ? 2'b10 : 2'b00, i == 3, i == 3, i == 2);
    drain();

    // Length clamp: 41 beats requested, 16 granted
    do_req(32'h3000_0100, 8'd40);
    chk("arlen_clamp", 128'(ARLEN), 128'(15));
    for (int i = 0; i < 16; i++) add_beat(64'hC000_0000_0000_0000 + 64'(i), 2'b00, i == 15, i == 15, 1'b0);
    drain();

    // Reset mid-burst with 2 beats buffered
    do_req(32'h0000_2000, 8'd3);
    for (int i = 0; i < 4; i++) add_beat(64'hA000_0000_0000_0000 + 64'(i), 2'b00, i == 3, i == 3, 1'b0);
    rsp_ready = 1'b0;
    repeat (4) cyc();
    chk("mid_rready_full", 128'(RREADY), 128'(0));
    chk("mid_rsp_valid", 128'(rsp_valid), 128'(1));
    ARESETn = 1'b0;
    s_q.delete(); exp_q.delete();
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_reset_outs", {req_ready, ARVALID, RREADY, rsp_valid, rsp_last, rsp_err, ARADDR, ARLEN, rsp_data}, '0);
      @(posedge ACLK); #1;
    end
    ARESETn = 1'b1;
    rsp_ready = 1'b1;
    cyc();
    chk("mid_req_ready", 128'(req_ready), 128'(1));
    chk("mid_no_rsp", 128'(rsp_valid), 128'(0));

`ifdef AXI_BURST_READER_LEN_CHECK_EN
    // Early RLAST on beat 1 of 4
    do_req(32'h0000_4000, 8'd3);
    add_beat(64'h1111_0000_0000_0000, 2'b00, 1'b0, 1'b0, 1'b0);
    add_beat(64'h1111_0000_0000_0001, 2'b00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20 && s_q.size() > 0; i++) cyc();
    chk("early_req_ready", 128'(req_ready), 128'(1));
    do_req(32'h0000_5000, 8'd0);
    chk("early_next_ar", 128'(ARVALID), 128'(1));
    add_beat(64'h2222_0000_0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
